// File: rtl/handle_rx_if.sv
// Bit-stream and result signals between the command decoder and the handle
// receiver. The decoder side uses master; the receiver uses slave.
interface handle_rx_if;
    logic        start;
    logic        bitin;
    logic        bitinvalid;
    logic [15:0] handle;
    logic [15:0] rxhandle;
    logic [4:0]  bitcount;
    logic        busy;
    logic        done;
    logic        match;
    logic        timeout;

    modport master (
        output start, bitin, bitinvalid, handle,
        input  rxhandle, bitcount, busy, done, match, timeout
    );

    modport slave (
        input  start, bitin, bitinvalid, handle,
        output rxhandle, bitcount, busy, done, match, timeout
    );
endinterface

// File: rtl/handle_rx.sv
// Serial MSB-first receiver for the 16-bit handle/RN16 with a registered match flag.
// Define HANDLE_RX_TIMEOUT_EN to build the idle-gap abort counter (TIMEOUT_CYCLES).
module handle_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic     clk,
    input  logic     reset,
    handle_rx_if.slave rx
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] rxhandle_q, rxhandle_d;
    logic [4:0]  bitcount_q, bitcount_d;
    logic        match_q, match_d;
    logic [15:0] shifted;

    assign shifted = {rxhandle_q[14:0], rx.bitin};

`ifdef HANDLE_RX_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

    logic [7:0] idle_q, idle_d;
    logic       timeout_q, timeout_d;
`else
    // The limit only matters when the idle counter is built.
    logic unused_timeout_param;
    assign unused_timeout_param = ^TIMEOUT_CYCLES[7:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rxhandle_q <= 16'h0000;
            bitcount_q <= 5'd0;
            match_q    <= 1'b0;
`ifdef HANDLE_RX_TIMEOUT_EN
            idle_q     <= 8'd0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rxhandle_q <= rxhandle_d;
            bitcount_q <= bitcount_d;
            match_q    <= match_d;
`ifdef HANDLE_RX_TIMEOUT_EN
            idle_q     <= idle_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        rxhandle_d = rxhandle_q;
        bitcount_d = bitcount_q;
        match_d    = match_q;
`ifdef HANDLE_RX_TIMEOUT_EN
        idle_d     = idle_q;
        timeout_d  = timeout_q;
`endif

        // start wins over everything, including a coincident strobe.
        if (rx.start) begin
            state_d    = SHIFT;
            rxhandle_d = 16'h0000;
            bitcount_d = 5'd0;
            match_d    = 1'b0;
`ifdef HANDLE_RX_TIMEOUT_EN
            idle_d     = 8'd0;
            timeout_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: ;
                SHIFT: begin
                    if (rx.bitinvalid) begin
                        rxhandle_d = shifted;
                        bitcount_d = bitcount_q + 5'd1;
`ifdef HANDLE_RX_TIMEOUT_EN
                        idle_d     = 8'd0;
`endif
                        if (bitcount_q == 5'd15) begin
                            state_d = DONE;
                            match_d = (shifted == rx.handle);
                        end
                    end
`ifdef HANDLE_RX_TIMEOUT_EN
                    // Partial rxhandle/bitcount are kept for debug after an abort.
                    else if (idle_q == TO_LIM) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        idle_d = idle_q + 8'd1;
                    end
`endif
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    assign rx.rxhandle = rxhandle_q;
    assign rx.bitcount = bitcount_q;
    assign rx.busy     = (state_q == SHIFT);
    assign rx.done     = (state_q == DONE);
    assign rx.match    = match_q;
`ifdef HANDLE_RX_TIMEOUT_EN
    assign rx.timeout  = timeout_q;
`else
    assign rx.timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_handle_rx.sv
// Self-checking bench for handle_rx: directed scenarios plus randomized captures
// checked against a word-level reference (expected word, bit count, equality).
module tb_handle_rx;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    handle_rx_if rx ();

    handle_rx #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rx.start      = 1'b0;
        rx.bitin      = 1'b0;
        rx.bitinvalid = 1'b0;
    endtask

    task automatic do_start();
        rx.start = 1'b1;
        tick();
        rx.start = 1'b0;
    endtask

    // Send bits [hi:0] of w MSB-first on consecutive cycles.
    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            rx.bitinvalid = 1'b1;
            rx.bitin      = w[i];
            tick();
        end
        rx.bitinvalid = 1'b0;
        rx.bitin      = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rx.handle = 16'h0000;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({rx.rxhandle, rx.bitcount, rx.busy, rx.done, rx.match, rx.timeout} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs got rx=%h cnt=%0d b=%b d=%b m=%b t=%b exp all zero",
                     rx.rxhandle, rx.bitcount, rx.busy, rx.done, rx.match, rx.timeout);
        end
    endtask

    task automatic test_match();
        rx.handle = 16'hA5C3;
        do_start();
        checks++;
        if (rx.busy !== 1'b1 || rx.done !== 1'b0) begin
            errors++;
            $display("FAIL match_busy_rise got busy=%b done=%b exp 1 0", rx.busy, rx.done);
        end
        send_bits(16'hA5C3 >> 1, 15);
        checks++;
        if (rx.done !== 1'b0 || rx.bitcount !== 5'd15) begin
            errors++;
            $display("FAIL match_15bits got done=%b cnt=%0d exp 0 15", rx.done, rx.bitcount);
        end
        send_bits(16'h0001, 1);
        checks++;
        if (rx.done !== 1'b1 || rx.match !== 1'b1 || rx.busy !== 1'b0 ||
            rx.rxhandle !== 16'hA5C3 || rx.bitcount !== 5'd16) begin
            errors++;
            $display("FAIL match_done got d=%b m=%b b=%b rx=%h cnt=%0d exp 1 1 0 a5c3 16",
                     rx.done, rx.match, rx.busy, rx.rxhandle, rx.bitcount);
        end
    endtask

    task automatic test_mismatch();
        rx.handle = 16'hA5C2;
        do_start();
        checks++;
        if (rx.match !== 1'b0 || rx.done !== 1'b0 || rx.bitcount !== 5'd0 || rx.rxhandle !== 16'h0) begin
            errors++;
            $display("FAIL mismatch_start_clear got m=%b d=%b cnt=%0d rx=%h exp 0 0 0 0000",
                     rx.match, rx.done, rx.bitcount, rx.rxhandle);
        end
        send_bits(16'hA5C3, 16);
        checks++;
        if (rx.done !== 1'b1 || rx.match !== 1'b0 || rx.rxhandle !== 16'hA5C3) begin
            errors++;
            $display("FAIL mismatch_done got d=%b m=%b rx=%h exp 1 0 a5c3",
                     rx.done, rx.match, rx.rxhandle);
        end
    endtask

    task automatic test_start_priority();
        rx.handle = 16'h0001;
        do_start();
        send_bits(16'hFFFF, 8);
        rx.start      = 1'b1;
        rx.bitinvalid = 1'b1;
        rx.bitin      = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (rx.bitcount !== 5'd0 || rx.rxhandle !== 16'h0000 || rx.busy !== 1'b1) begin
            errors++;
            $display("FAIL start_prio_clear got cnt=%0d rx=%h busy=%b exp 0 0000 1",
                     rx.bitcount, rx.rxhandle, rx.busy);
        end
        send_bits(16'h0001, 16);
        checks++;
        if (rx.rxhandle !== 16'h0001 || rx.match !== 1'b1 || rx.done !== 1'b1) begin
            errors++;
            $display("FAIL start_prio_done got rx=%h m=%b d=%b exp 0001 1 1",
                     rx.rxhandle, rx.match, rx.done);
        end
    endtask

    task automatic test_reset_midcapture();
        rx.handle = 16'h1234;
        do_start();
        send_bits(16'h03FF, 10);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({rx.rxhandle, rx.bitcount, rx.busy, rx.done, rx.match, rx.timeout} !== 26'd0) begin
            errors++;
            $display("FAIL reset_async got rx=%h cnt=%0d b=%b d=%b exp all zero",
                     rx.rxhandle, rx.bitcount, rx.busy, rx.done);
        end
        tick();
        reset = 1'b0;
        send_bits(16'hFFFF, 3);
        checks++;
        if (rx.bitcount !== 5'd0 || rx.busy !== 1'b0 || rx.rxhandle !== 16'h0) begin
            errors++;
            $display("FAIL reset_idle_ignores got cnt=%0d busy=%b rx=%h exp 0 0 0000",
                     rx.bitcount, rx.busy, rx.rxhandle);
        end
    endtask

    task automatic test_done_hold();
        rx.handle = 16'h5A5A;
        do_start();
        send_bits(16'h5A5A, 16);
        send_bits(16'hFFFF, 5);
        rx.handle = 16'h0000;
        tick();
        checks++;
        if (rx.rxhandle !== 16'h5A5A || rx.match !== 1'b1 || rx.bitcount !== 5'd16 || rx.done !== 1'b1) begin
            errors++;
            $display("FAIL done_hold got rx=%h m=%b cnt=%0d d=%b exp 5a5a 1 16 1",
                     rx.rxhandle, rx.match, rx.bitcount, rx.done);
        end
    endtask

    // Random words, random gaps (within the idle limit), random restarts.
    task automatic test_random();
        logic [15:0] word;
        logic [15:0] hnd;
        int          sent;
        for (int t = 0; t < 25; t++) begin
            word = 16'($urandom);
            hnd  = ($urandom_range(0, 1) == 1) ? word : word ^ (16'h1 << $urandom_range(0, 15));
            rx.handle = hnd;
            rx.start  = 1'b1;
            for (int k = $urandom_range(1, 3); k > 0; k--) begin
                rx.bitinvalid = 1'($urandom);
                rx.bitin      = 1'($urandom);
                tick();
            end
            idle_inputs();
            sent = 0;
            for (int i = 15; i >= 0; i--) begin
                for (int g = $urandom_range(0, 3); g > 0; g--) tick();
                rx.bitinvalid = 1'b1;
                rx.bitin      = word[i];
                tick();
                rx.bitinvalid = 1'b0;
                sent++;
                if (sent == 8) begin
                    checks++;
                    if (rx.bitcount !== 5'd8 || rx.rxhandle !== {8'h00, word[15:8]} || rx.busy !== 1'b1) begin
                        errors++;
                        $display("FAIL rand_half t=%0d got cnt=%0d rx=%h exp 8 %h",
                                 t, rx.bitcount, rx.rxhandle, {8'h00, word[15:8]});
                    end
                end
            end
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            checks++;
            if (rx.done !== 1'b1 || rx.rxhandle !== word || rx.bitcount !== 5'd16 ||
                rx.match !== (word == hnd)) begin
                errors++;
                $display("FAIL rand_done t=%0d got d=%b rx=%h cnt=%0d m=%b exp 1 %h 16 %b",
                         t, rx.done, rx.rxhandle, rx.bitcount, rx.match, word, word == hnd);
            end
        end
    endtask

`ifdef HANDLE_RX_TIMEOUT_EN
    task automatic test_timeout();
        rx.handle = 16'h0000;
        do_start();
        send_bits(16'h0005, 3);
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (rx.timeout !== 1'b0 || rx.busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early got t=%b busy=%b exp 0 1", rx.timeout, rx.busy);
        end
        tick();
        checks++;
        if (rx.timeout !== 1'b1 || rx.busy !== 1'b0 || rx.bitcount !== 5'd3 ||
            rx.rxhandle !== 16'h0005 || rx.match !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fire got t=%b busy=%b cnt=%0d rx=%h m=%b exp 1 0 3 0005 0",
                     rx.timeout, rx.busy, rx.bitcount, rx.rxhandle, rx.match);
        end
        send_bits(16'hFFFF, 2);
        checks++;
        if (rx.timeout !== 1'b1 || rx.bitcount !== 5'd3) begin
            errors++;
            $display("FAIL timeout_sticky got t=%b cnt=%0d exp 1 3", rx.timeout, rx.bitcount);
        end
        do_start();
        checks++;
        if (rx.timeout !== 1'b0 || rx.busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_clear got t=%b busy=%b exp 0 1", rx.timeout, rx.busy);
        end
        // A strobe on the cycle the limit is reached is still accepted.
        send_bits(16'h0001, 1);
        for (int i = 0; i < 4; i++) tick();
        send_bits(16'h0001, 1);
        checks++;
        if (rx.timeout !== 1'b0 || rx.busy !== 1'b1 || rx.bitcount !== 5'd2) begin
            errors++;
            $display("FAIL timeout_limit_strobe got t=%b busy=%b cnt=%0d exp 0 1 2",
                     rx.timeout, rx.busy, rx.bitcount);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        idle_inputs();
        rx.handle = 16'h0000;
        test_reset();
        test_match();
        test_mismatch();
        test_start_priority();
        test_reset_midcapture();
        test_done_hold();
        test_random();
`ifdef HANDLE_RX_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/handle_rx.md
# handle_rx

Serial receiver for the 16-bit handle/RN16 that the reader echoes back in ACK, Req_RN and access commands. It shifts in bits delivered by the command decoder MSB-first, the same bit order the tag uses to backscatter its handle. After 16 bits it compares the assembled word against the tag's current handle and reports a registered match flag. The command FSM uses the flag to gate the RNG's bit clock and to accept or drop the command.

## Interface
- `TIMEOUT_CYCLES`, default 255: idle clocks allowed between bits in SHIFT before the capture is aborted. Legal range 1–255. Used only with the configuration macro.

- `clk`  in  1  block clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; clears the block and begins a new capture.
- `bitin`  in  1  received data bit; sampled only when `bitinvalid`=1.
- `bitinvalid`  in  1  strobe qualifying `bitin`; one bit per high cycle.
- `handle`  in  16  tag's current handle; must be stable during SHIFT.
- `rxhandle`  out  16  assembled received word, MSB first.
- `bitcount`  out  5  bits captured so far, 0..16.
- `busy`  out  1  high in SHIFT.
- `done`  out  1  high in DONE.
- `match`  out  1  valid when `done`=1; high if `rxhandle`==`handle`.
- `timeout`  out  1  sticky abort flag (see Configuration).

## Operation
- States: IDLE, SHIFT, DONE. Encoded as 2 bits; the unused encoding returns to IDLE.
- Reset value of every output is 0: `rxhandle`=16'h0000, `bitcount`=0, `busy`=`done`=`match`=`timeout`=0. The state resets to IDLE.
- `start`, from any state:
  - Next state is SHIFT.
  - Clears `rxhandle`, `bitcount`, `match` and `timeout`.
  - Has priority over `bitinvalid` in the same cycle; that bit is discarded.
- SHIFT, on a cycle with `bitinvalid`=1:
  - `rxhandle` <= {`rxhandle`[14:0], `bitin`}.
  - `bitcount` increments.
- On the 16th bit, i.e. `bitcount`==15 and `bitinvalid`=1:
  - Next state is DONE.
  - `bitcount` becomes 16.
  - `match` <= ({`rxhandle`[14:0], `bitin`} == `handle`), evaluated at that edge.
- DONE holds `rxhandle`, `match` and `bitcount` until the next `start`. Further `bitinvalid` pulses are ignored.
- IDLE ignores `bitinvalid`. Reaching IDLE from reset, or from a timeout, leaves `match`=0.
- `bitcount` never exceeds 16 and never wraps.
- Asserting `reset` mid-capture aborts immediately. All outputs go to 0 asynchronously.
- `handle` changing in DONE does not update `match`, because `match` is registered.

## Timing
- Capture latency: `done` and `match` are valid on the cycle after the edge that samples the 16th valid bit.
- With back-to-back strobes, the earliest `done` is 16 cycles after `start` deasserts.
- `busy` rises on the cycle after `start`. `busy` falls on the same edge that `done` rises.
- There is no minimum spacing between strobes. `bitinvalid` may be high on consecutive cycles.
- `start` is edge-independent: a level held for N cycles behaves as N restarts. The capture begins after the last of them.

## Configuration
- Macro: `HANDLE_RX_TIMEOUT_EN`.
- Defined:
  - An 8-bit idle counter clears on `start` and on every accepted bit. It increments on each SHIFT cycle without `bitinvalid`.
  - When the counter reaches `TIMEOUT_CYCLES`, the next state is IDLE and `timeout` is set.
  - `rxhandle` and `bitcount` keep their partial values.
  - `timeout` stays high until `start` or `reset`.
  - If a strobe arrives in the same cycle the limit is reached, the bit is accepted and no timeout occurs.
- Undefined: no counter is built and `timeout` is tied to 0. SHIFT waits indefinitely for bits.

## Test plan
- Reset, then `start`, then 16 back-to-back bits of 16'hA5C3 with `handle`=16'hA5C3 -> `done`=1 and `match`=1 on the 17th cycle after `start`; `rxhandle`=16'hA5C3, `bitcount`=16.
- Same stream with `handle`=16'hA5C2 -> `done`=1, `match`=0, `rxhandle`=16'hA5C3.
- 8 bits of 16'hFFFF, then `start` together with a strobe, then 16 bits of 16'h0001 -> the coincident bit is discarded; `rxhandle`=16'h0001 and `match`=1 against `handle`=16'h0001.
- `reset` pulse after 10 bits -> all outputs 0 and state IDLE; subsequent strobes leave `bitcount`=0.
- In DONE, 5 extra strobes with `bitin`=1, then change `handle` -> `rxhandle`, `match` and `bitcount`=16 are unchanged.
- With `HANDLE_RX_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4: 3 bits then silence -> `timeout`=1, `busy`=0, `bitcount`=3 five cycles after the last bit; the next `start` clears `timeout`.
